// File: rtl/aes_round_engine.sv
// ============================================================================
// Module      : aes_round_engine
// Description : Iterative AES-128 encryption core, one cipher round per clock,
//               pre-expanded round keys, valid/ready in and out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_round_engine (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   plaintext,
  input  logic [1407:0]  roundkey_array,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   ciphertext,
  output logic           busy,
  output logic [3:0]     round_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [127:0]  st;
  logic [127:0]  rk;
  logic [127:0]  round_out;
  logic [127:0]  pre_ark;
  logic          last_round;
  logic [7:0]    sb [16];
  logic [7:0]    sr [16];
  logic [7:0]    mc [16];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 via a short addition chain (0 maps to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = gf_inv(x);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    rk = '0;
    for (int r = 0; r <= 10; r++) begin
      if (round_idx == 4'(r)) rk = roundkey_array[1407 - 128*r -: 128];
    end
  end

  assign last_round = (round_idx == 4'd10);

  genvar gi, gr, gc;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_sub
      assign sb[gi] = sbox(st[127 - 8*gi -: 8]);
    end

    // Byte index is row + 4*column; row r takes its bytes from column c + r.
    for (gr = 0; gr < 4; gr++) begin : g_shift_row
      for (gc = 0; gc < 4; gc++) begin : g_shift_col
        assign sr[gr + 4*gc] = sb[gr + 4*((gc + gr) % 4)];
      end
    end

    for (gc = 0; gc < 4; gc++) begin : g_mix
      assign mc[4*gc]   = xtime(sr[4*gc]) ^ xtime(sr[4*gc+1]) ^ sr[4*gc+1] ^ sr[4*gc+2] ^ sr[4*gc+3];
      assign mc[4*gc+1] = sr[4*gc] ^ xtime(sr[4*gc+1]) ^ xtime(sr[4*gc+2]) ^ sr[4*gc+2] ^ sr[4*gc+3];
      assign mc[4*gc+2] = sr[4*gc] ^ sr[4*gc+1] ^ xtime(sr[4*gc+2]) ^ xtime(sr[4*gc+3]) ^ sr[4*gc+3];
      assign mc[4*gc+3] = xtime(sr[4*gc]) ^ sr[4*gc] ^ sr[4*gc+1] ^ sr[4*gc+2] ^ xtime(sr[4*gc+3]);
    end

    for (gi = 0; gi < 16; gi++) begin : g_pack
      assign pre_ark[127 - 8*gi -: 8] = last_round ? sr[gi] : mc[gi];
    end
  endgenerate

  assign round_out = pre_ark ^ rk;
  assign in_ready  = (state == IDLE) && rst_n;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      st         <= '0;
      round_idx  <= 4'd0;
      out_valid  <= 1'b0;
      ciphertext <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st        <= plaintext ^ roundkey_array[1407:1280];
            round_idx <= 4'd1;
            state     <= ROUND;
          end
        end
        ROUND: begin
          st        <= round_out;
          round_idx <= round_idx + 4'd1;
          if (last_round) begin
            ciphertext <= round_out;
            out_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            round_idx <= 4'd0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_round_engine.sv
// ============================================================================
// Module      : tb_aes_round_engine
// Description : Self-checking bench for aes_round_engine with FIPS-197 vectors
//               and random blocks against a byte-level AES reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_round_engine;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   plaintext;
  logic [1407:0]  roundkey_array;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   ciphertext;
  logic           busy;
  logic [3:0]     round_idx;

  always #5 clk = ~clk;

  aes_round_engine dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .plaintext      (plaintext),
    .roundkey_array (roundkey_array),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .ciphertext     (ciphertext),
    .busy           (busy),
    .round_idx      (round_idx)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  sbox_t [256];
  vec_t        vecs [3];

  function automatic logic [7:0] mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box from exp/log tables over generator 3, then the affine bit formula.
  task automatic build_sbox();
    logic [7:0] ex [256];
    int         lg [256];
    logic [7:0] v, inv, s, c;
    c = 8'h63;
    v = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = v;
      lg[v] = i;
      v = v ^ mul2(v);
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = mul2(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      res[1407 - 128*r -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [1407:0] rka;
    logic [7:0]    b [16];
    logic [7:0]    t [16];
    logic [7:0]    a0, a1, a2, a3;
    logic [127:0]  res;
    rka = expand(key);
    for (int i = 0; i < 16; i++) b[i] = pt[127 - 8*i -: 8] ^ rka[1407 - 8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) b[i] = sbox_t[b[i]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r + 4*c] = b[r + 4*((c + r) % 4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 10) begin
          b[4*c]   = mul2(a0) ^ mul2(a1) ^ a1 ^ a2 ^ a3;
          b[4*c+1] = a0 ^ mul2(a1) ^ mul2(a2) ^ a2 ^ a3;
          b[4*c+2] = a0 ^ a1 ^ mul2(a2) ^ mul2(a3) ^ a3;
          b[4*c+3] = mul2(a0) ^ a0 ^ a1 ^ a2 ^ mul2(a3);
        end else begin
          b[4*c] = a0; b[4*c+1] = a1; b[4*c+2] = a2; b[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) b[i] = b[i] ^ rka[1407 - 128*rnd - 8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = b[i];
    return res;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input logic [127:0] key, input logic [127:0] pt,
                           input logic [127:0] exp, input string name,
                           input bit stall, input bit disturb);
    int cyc;
    bit step_ok;
    roundkey_array = expand(key);
    plaintext = pt;
    in_valid  = 1'b1;
    out_ready = !stall;
    check({name, " in_ready_before"}, 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    if (disturb) begin
      plaintext = '1;
      in_valid  = 1'b1;
    end
    cyc = 0;
    step_ok = 1'b1;
    while (!out_valid && cyc < 20) begin
      if (round_idx != 4'(cyc + 1)) step_ok = 1'b0;
      tick();
      cyc++;
      if (cyc == 8) in_valid = 1'b0;
    end
    check({name, " latency"}, 128'(cyc), 128'd10);
    check({name, " round_step"}, 128'(step_ok), 128'd1);
    check({name, " ciphertext"}, ciphertext, exp);
    if (stall) begin
      for (int i = 0; i < 5; i++) begin
        tick();
        check({name, " hold_ct"}, ciphertext, exp);
        check({name, " hold_ctl"}, {out_valid, in_ready, round_idx}, {1'b1, 1'b0, 4'd11});
      end
      out_ready = 1'b1;
    end
    tick();
    check({name, " post_handshake"}, {out_valid, busy, in_ready, round_idx},
          {1'b0, 1'b0, 1'b1, 4'd0});
  endtask

  initial begin
    logic [127:0] rkey, rpt;
    int n, acc, done_cnt, last_t;
    build_sbox();
    vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                pt:  128'h3243f6a8885a308d313198a2e0370734,
                ct:  128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                pt:  128'h00112233445566778899aabbccddeeff,
                ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{key: 128'h0, pt: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    plaintext = '0; roundkey_array = '0;
    tick(); tick();
    check("reset_state", {out_valid, busy, in_ready, round_idx}, 128'd0);
    check("reset_ct", ciphertext, 128'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_release", 128'(in_ready), 128'd1);

    // Known-answer table: App. B plain, App. C.1 with stall, zero with disturbance.
    for (int i = 0; i < 3; i++)
      run_block(vecs[i].key, vecs[i].pt, vecs[i].ct, $sformatf("kat%0d", i), i == 1, i == 2);

    // Back-to-back alternating B / C.1 with in_valid and out_ready held high.
    n = 4; acc = 1; done_cnt = 0; last_t = 0;
    roundkey_array = expand(vecs[0].key);
    plaintext = vecs[0].pt;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int t = 1; t <= 80 && done_cnt < n; t++) begin
      tick();
      if (out_valid) begin
        check("b2b_ct", ciphertext, vecs[done_cnt % 2].ct);
        if (done_cnt > 0) check("b2b_interval", 128'(t - last_t), 128'd12);
        last_t = t;
        done_cnt++;
      end
      if (in_ready) begin
        if (acc < n) begin
          roundkey_array = expand(vecs[acc % 2].key);
          plaintext = vecs[acc % 2].pt;
          acc++;
        end else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("b2b_count", 128'(done_cnt), 128'(n));
    tick();

    // Reset in the middle of round 5.
    roundkey_array = expand(vecs[0].key);
    plaintext = vecs[0].pt;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (round_idx != 4'd5 && n < 20) begin tick(); n++; end
    check("mid_reset_reach5", 128'(round_idx), 128'd5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_reset_ctl", {out_valid, busy, in_ready}, {1'b0, 1'b0, 1'b1});
    check("mid_reset_ct", ciphertext, 128'd0);
    run_block(vecs[0].key, vecs[0].pt, vecs[0].ct, "after_reset", 1'b0, 1'b0);

    // Reset while waiting in DONE with out_ready low.
    roundkey_array = expand(vecs[1].key);
    plaintext = vecs[1].pt;
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("done_reached", {127'd0, out_valid}, 128'd1);
    rst_n = 1'b0;
    tick();
    check("done_reset_ctl", {out_valid, busy, round_idx}, 128'd0);
    check("done_reset_ct", ciphertext, 128'd0);
    rst_n = 1'b1;
    #1;
    check("done_reset_ready", 128'(in_ready), 128'd1);

    // Random blocks against the reference model.
    for (int i = 0; i < 6; i++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      rpt  = {$urandom, $urandom, $urandom, $urandom};
      run_block(rkey, rpt, ref_encrypt(rkey, rpt), $sformatf("rand%0d", i), i == 3, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
